// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID (word 0) and build timestamp (word 1)
// from a sysid slave, compares both with expected values and reports pass/fail/timeout.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] read_id,
   output logic [31:0] read_ts,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic [2:0]  dbg_state
);

   // Avalon-MM read handshake: a read is accepted in a cycle where avm_read=1 and
   // avm_waitrequest=0; address/read hold steady until then. Data returns in any later
   // cycle (or the accept cycle itself) flagged by avm_readdatavalid. One read outstanding.

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ID_REQ  = 3'd1,
      S_ID_WAIT = 3'd2,
      S_TS_REQ  = 3'd3,
      S_TS_WAIT = 3'd4,
      S_FIN     = 3'd5
   } state_t;

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] count;
   logic        in_req;
   logic        active;
   logic        id_take;
   logic        ts_take;
   logic        expire;
   logic        accept_start;
   logic        entering_req;

   always_comb begin
      in_req       = (state == S_ID_REQ) || (state == S_TS_REQ);
      active       = in_req || (state == S_ID_WAIT) || (state == S_TS_WAIT);
      id_take      = avm_readdatavalid &&
                     (((state == S_ID_REQ) && !avm_waitrequest) || (state == S_ID_WAIT));
      ts_take      = avm_readdatavalid &&
                     (((state == S_TS_REQ) && !avm_waitrequest) || (state == S_TS_WAIT));
      // A completion in the final allowed cycle wins over the timeout.
      expire       = active && (count == LAST_COUNT) && !id_take && !ts_take;
      accept_start = (state == S_IDLE) && start;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_ID_REQ;
         end
         S_ID_REQ: begin
            if (id_take)               state_next = S_TS_REQ;
            else if (expire)           state_next = S_FIN;
            else if (!avm_waitrequest) state_next = S_ID_WAIT;
         end
         S_ID_WAIT: begin
            if (id_take)     state_next = S_TS_REQ;
            else if (expire) state_next = S_FIN;
         end
         S_TS_REQ: begin
            if (ts_take || expire)     state_next = S_FIN;
            else if (!avm_waitrequest) state_next = S_TS_WAIT;
         end
         S_TS_WAIT: begin
            if (ts_take || expire) state_next = S_FIN;
         end
         S_FIN: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      entering_req = ((state_next == S_ID_REQ) && (state != S_ID_REQ)) ||
                     ((state_next == S_TS_REQ) && (state != S_TS_REQ));
      busy         = active;
      dbg_state    = state;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Per-transaction cycle counter; restarts for each of the two reads.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= 16'd0;
      end else if (entering_req) begin
         count <= 16'd0;
      end else if (active) begin
         count <= count + 16'd1;
      end
   end

   // Bus outputs follow the next state so they are valid in the first request cycle
   // and drop the cycle after acceptance or timeout.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
      end else begin
         avm_read    <= (state_next == S_ID_REQ) || (state_next == S_TS_REQ);
         avm_address <= (state_next == S_TS_REQ);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
      end else begin
         done <= (state == S_FIN);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_id <= 32'd0;
         read_ts <= 32'd0;
         id_ok   <= 1'b0;
         ts_ok   <= 1'b0;
         timeout <= 1'b0;
      end else if (accept_start) begin
         read_id <= 32'd0;
         read_ts <= 32'd0;
         id_ok   <= 1'b0;
         ts_ok   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (id_take) begin
            read_id <= avm_readdata;
            id_ok   <= (avm_readdata == EXPECTED_ID);
         end
         if (ts_take) begin
            read_ts <= avm_readdata;
            ts_ok   <= (avm_readdata == EXPECTED_TS);
         end
         if (expire) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Self-checking bench for soc_system_sysid_checker: directed table, corner sequences and
// randomized slave timing checked against a transaction-level model.
module tb_soc_system_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'hCAFE0001;
   localparam logic [31:0] EXP_TS = 32'h5A5A0002;
   localparam int          TOUT   = 8;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout;
   logic [31:0] read_id;
   logic [31:0] read_ts;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic [2:0]  dbg_state;

   soc_system_sysid_checker #(
      .EXPECTED_ID(EXP_ID),
      .EXPECTED_TS(EXP_TS),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .start(start),
      .busy(busy),
      .done(done),
      .id_ok(id_ok),
      .ts_ok(ts_ok),
      .timeout(timeout),
      .read_id(read_id),
      .read_ts(read_ts),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   // slave configuration, indexed by word address
   int          cfg_wait[2];
   int          cfg_dly[2];
   bit          cfg_resp[2];
   logic [31:0] cfg_data[2];
   bit          stray_req;
   logic [31:0] stray_data;

   typedef struct {
      int          w_id;
      int          d_id;
      bit          r_id;
      logic [31:0] dat_id;
      int          w_ts;
      int          d_ts;
      bit          r_ts;
      logic [31:0] dat_ts;
      bit          e_id;
      bit          e_ts;
      bit          e_to;
      logic [31:0] e_rid;
      logic [31:0] e_rts;
      int          e_lat;
   } row_t;

   row_t rows[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Behavioural slave: per-address stall count, response delay (0 = same cycle as
   // acceptance) and optional silence; also injects a stray valid on request.
   task automatic slave_loop();
      int   wait_seen = 0;
      int   pend_left = 0;
      int   pend_addr = 0;
      bit   was_stalled = 0;
      logic stall_addr = 1'b0;
      int   a;
      forever begin
         @(negedge clock);
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         if (!reset_n) begin
            wait_seen   = 0;
            pend_left   = 0;
            was_stalled = 0;
            stray_req   = 0;
         end else begin
            if (was_stalled && busy)
               check("bus_stable", 32'({avm_read, avm_address}), 32'({1'b1, stall_addr}));
            was_stalled = 0;
            if (pend_left > 0) begin
               pend_left--;
               if (pend_left == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = cfg_data[pend_addr];
               end
            end
            if (stray_req) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = stray_data;
               stray_req         = 0;
            end
            if (!avm_read) begin
               wait_seen = 0;
            end else begin
               a = int'(avm_address);
               if (wait_seen < cfg_wait[a]) begin
                  avm_waitrequest = 1'b1;
                  wait_seen++;
                  was_stalled = 1;
                  stall_addr  = avm_address;
               end else begin
                  wait_seen = 0;
                  check("one_outstanding", 32'(pend_left), 32'd0);
                  if (cfg_resp[a]) begin
                     if (cfg_dly[a] == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = cfg_data[a];
                     end else begin
                        pend_left = cfg_dly[a];
                        pend_addr = a;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic apply_cfg(input row_t r);
      cfg_wait[0] = r.w_id;  cfg_dly[0] = r.d_id;  cfg_resp[0] = r.r_id;  cfg_data[0] = r.dat_id;
      cfg_wait[1] = r.w_ts;  cfg_dly[1] = r.d_ts;  cfg_resp[1] = r.r_ts;  cfg_data[1] = r.dat_ts;
   endtask

   // Transaction-level expectation: each read takes wait+1+delay cycles and fails if
   // the slave is silent or that exceeds TOUT; done appears two cycles after the last phase.
   task automatic model(output bit e_id, output bit e_ts, output bit e_to,
                        output logic [31:0] e_rid, output logic [31:0] e_rts, output int e_lat);
      int n0 = cfg_wait[0] + 1 + cfg_dly[0];
      int n1 = cfg_wait[1] + 1 + cfg_dly[1];
      e_id = 0; e_ts = 0; e_to = 0; e_rid = 32'd0; e_rts = 32'd0;
      if (!cfg_resp[0] || n0 > TOUT) begin
         e_to  = 1;
         e_lat = 2 + TOUT;
      end else begin
         e_rid = cfg_data[0];
         e_id  = (cfg_data[0] == EXP_ID);
         if (!cfg_resp[1] || n1 > TOUT) begin
            e_to  = 1;
            e_lat = 2 + n0 + TOUT;
         end else begin
            e_rts = cfg_data[1];
            e_ts  = (cfg_data[1] == EXP_TS);
            e_lat = 2 + n0 + n1;
         end
      end
   endtask

   // driver: pulse start, observe a fixed window; noisy mode re-pulses start while busy
   // and in the FIN cycle, then fires a stray readdatavalid once idle.
   task automatic run_check(input bit noisy, output int lat, output int dones);
      lat   = -1;
      dones = 0;
      @(negedge clock);
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         start = 1'b0;
         if (done) begin
            dones++;
            if (lat < 0) lat = k;
         end
         if (noisy && lat < 0) start = 1'b1;
         if (noisy && lat > 0 && k == lat + 3) begin
            stray_data = ~cfg_data[0];
            stray_req  = 1;
         end
      end
   endtask

   task automatic score(input string tag, input bit e_id, input bit e_ts, input bit e_to,
                        input int e_lat, input int lat, input int dones);
      logic [31:0] e_word;
      check($sformatf("%s_latency", tag), 32'(lat), 32'(e_lat));
      check($sformatf("%s_done_count", tag), 32'(dones), 32'd1);
      check($sformatf("%s_flags", tag), 32'({id_ok, ts_ok, timeout}), 32'({e_id, e_ts, e_to}));
      e_word = exp_q.pop_front();
      check($sformatf("%s_read_id", tag), read_id, e_word);
      e_word = exp_q.pop_front();
      check($sformatf("%s_read_ts", tag), read_ts, e_word);
      check($sformatf("%s_idle", tag), 32'({busy, avm_read}), 32'd0);
   endtask

   task automatic reset_mid(input string tag, input int w_id, input int d_id,
                            input int cycles_in, input bit exp_read);
      row_t r;
      r = rows[0];
      r.w_id = w_id;
      r.d_id = d_id;
      apply_cfg(r);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (cycles_in - 1) @(negedge clock);
      check($sformatf("%s_before", tag), 32'({busy, avm_read}), 32'({1'b1, exp_read}));
      #2 reset_n = 1'b0;
      #1;
      check($sformatf("%s_ctrl_zero", tag),
            32'({busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}), 32'd0);
      check($sformatf("%s_words_zero", tag), read_id | read_ts, 32'd0);
      @(negedge clock);
      @(negedge clock);
      #2 reset_n = 1'b1;
      begin
         int dones = 0;
         repeat (4) begin
            @(negedge clock);
            if (done) dones++;
         end
         check($sformatf("%s_no_done", tag), 32'(dones), 32'd0);
      end
      check($sformatf("%s_state_idle", tag), 32'(dbg_state), 32'd0);
   endtask

   initial begin
      int lat;
      int dones;
      bit e_id;
      bit e_ts;
      bit e_to;
      logic [31:0] e_rid;
      logic [31:0] e_rts;
      int e_lat;

      //                w_id d_id r_id dat_id        w_ts d_ts r_ts dat_ts        id ts to e_rid         e_rts         lat
      rows[0] = '{0, 0, 1, 32'hCAFE0001, 0, 0, 1, 32'h5A5A0002, 1, 1, 0, 32'hCAFE0001, 32'h5A5A0002, 4};
      rows[1] = '{0, 0, 1, 32'hCAFE0000, 0, 0, 1, 32'h5A5A0002, 0, 1, 0, 32'hCAFE0000, 32'h5A5A0002, 4};
      rows[2] = '{3, 2, 1, 32'hCAFE0001, 3, 2, 1, 32'h5A5A0002, 1, 1, 0, 32'hCAFE0001, 32'h5A5A0002, 14};
      rows[3] = '{0, 0, 1, 32'hCAFE0001, 0, 0, 0, 32'h5A5A0002, 1, 0, 1, 32'hCAFE0001, 32'h00000000, 11};
      rows[4] = '{0, 0, 0, 32'hCAFE0001, 0, 0, 1, 32'h5A5A0002, 0, 0, 1, 32'h00000000, 32'h00000000, 10};
      rows[5] = '{7, 0, 1, 32'hCAFE0001, 0, 0, 1, 32'h5A5A0003, 1, 0, 0, 32'hCAFE0001, 32'h5A5A0003, 11};
      rows[6] = '{3, 5, 1, 32'hCAFE0001, 0, 0, 1, 32'h5A5A0002, 0, 0, 1, 32'h00000000, 32'h00000000, 10};
      rows[7] = '{10, 0, 1, 32'hCAFE0001, 0, 0, 1, 32'h5A5A0002, 0, 0, 1, 32'h00000000, 32'h00000000, 10};

      reset_n           = 1'b0;
      start             = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = 32'd0;
      avm_readdatavalid = 1'b0;
      stray_req         = 0;
      stray_data        = 32'd0;
      apply_cfg(rows[0]);
      fork
         slave_loop();
      join_none

      repeat (3) @(negedge clock);
      check("reset_ctrl", 32'({busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}), 32'd0);
      check("reset_words", read_id | read_ts, 32'd0);
      #2 reset_n = 1'b1;
      @(negedge clock);
      check("post_reset_idle", 32'({busy, done, avm_read}), 32'd0);

      for (int i = 0; i < 8; i++) begin
         apply_cfg(rows[i]);
         run_check(1'b0, lat, dones);
         exp_q.push_back(rows[i].e_rid);
         exp_q.push_back(rows[i].e_rts);
         score($sformatf("row%0d", i), rows[i].e_id, rows[i].e_ts, rows[i].e_to,
               rows[i].e_lat, lat, dones);
      end

      // start while busy and in FIN, stray readdatavalid once idle
      apply_cfg(rows[2]);
      run_check(1'b1, lat, dones);
      exp_q.push_back(rows[2].e_rid);
      exp_q.push_back(rows[2].e_rts);
      score("noisy", rows[2].e_id, rows[2].e_ts, rows[2].e_to, rows[2].e_lat, lat, dones);

      reset_mid("rst_id_wait", 0, 6, 2, 1'b0);
      apply_cfg(rows[0]);
      run_check(1'b0, lat, dones);
      exp_q.push_back(rows[0].e_rid);
      exp_q.push_back(rows[0].e_rts);
      score("after_rst1", 1, 1, 0, 4, lat, dones);

      reset_mid("rst_id_req", 6, 0, 3, 1'b1);
      apply_cfg(rows[1]);
      run_check(1'b0, lat, dones);
      exp_q.push_back(rows[1].e_rid);
      exp_q.push_back(rows[1].e_rts);
      score("after_rst2", 0, 1, 0, 4, lat, dones);

      for (int i = 0; i < 24; i++) begin
         for (int a = 0; a < 2; a++) begin
            cfg_wait[a] = $urandom_range(0, 4);
            cfg_dly[a]  = $urandom_range(0, 4);
            cfg_resp[a] = ($urandom_range(0, 9) != 0);
            cfg_data[a] = (a == 0) ? EXP_ID : EXP_TS;
            if ($urandom_range(0, 2) == 0) cfg_data[a] = cfg_data[a] ^ (32'd1 << $urandom_range(0, 31));
         end
         model(e_id, e_ts, e_to, e_rid, e_rts, e_lat);
         run_check(1'b0, lat, dones);
         exp_q.push_back(e_rid);
         exp_q.push_back(e_rts);
         score($sformatf("rand%0d", i), e_id, e_ts, e_to, e_lat, lat, dones);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
